pc_ras_unit: RTL and testbench

//  Next-generation program-counter unit for the stack-based multi-cycle core.

---
 rtl/pc_ras_if.sv | 31 +++
 rtl/pc_ras_unit.sv | 99 +++++++++
 tb/tb_pc_ras_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pc_ras_if.sv
// Control-side bundle for the PC / return-address-stack unit.
// The control FSM is the master; pc_ras_unit is the slave.
interface pc_ras_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int RAS_DEPTH  = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic                  enable;
  logic [2:0]            op;
  logic [ADDR_WIDTH-1:0] target;
  logic                  cond;
  logic                  clr_err;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] ras_top;
  logic [CNT_W-1:0]      ras_count;
  logic                  ras_full;
  logic                  ras_empty;
  logic                  err_overflow;
  logic                  err_underflow;

  modport master (
    output enable, op, target, cond, clr_err,
    input  pc, ras_top, ras_count, ras_full, ras_empty, err_overflow, err_underflow
  );

  modport slave (
    input  enable, op, target, cond, clr_err,
    output pc, ras_top, ras_count, ras_full, ras_empty, err_overflow, err_underflow
  );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with increment/jump/branch/call/return sequencing and a
// circular return-address stack with sticky overflow/underflow flags.
module pc_ras_unit #(
  parameter int                    ADDR_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INC_STEP     = 1,
  parameter int                    RAS_DEPTH    = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  pc_ras_if.slave bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(INC_STEP);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(RAS_DEPTH);

  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [PTR_W-1:0]      ptr_q, ptr_d, top_idx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, unf_q;
  logic                  set_ovf, set_unf, push;
  logic                  full, empty;
  logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];

  assign pc_inc  = pc_q + STEP;
  assign top_idx = ptr_q - PTR_W'(1);
  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);

  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.enable) begin
      case (bus.op)
        OP_INC:    pc_d = pc_inc;
        OP_JUMP:   pc_d = bus.target;
        OP_BRANCH: pc_d = bus.cond ? bus.target : pc_inc;
        OP_CALL: begin
          // A full stack still takes the push, silently dropping the oldest entry.
          push  = 1'b1;
          pc_d  = bus.target;
          ptr_d = ptr_q + PTR_W'(1);
          if (full) set_ovf = 1'b1;
          else      cnt_d   = cnt_q + CNT_W'(1);
        end
        OP_RET: begin
          if (empty) begin
            set_unf = 1'b1;
          end else begin
            pc_d  = mem[top_idx];
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      // A fresh error in the clearing cycle takes priority over the clear.
      ovf_q <= set_ovf | (ovf_q & ~bus.clr_err);
      unf_q <= set_unf | (unf_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= pc_inc;
  end

  assign bus.pc            = pc_q;
  assign bus.ras_top       = empty ? '0 : mem[top_idx];
  assign bus.ras_count     = cnt_q;
  assign bus.ras_full      = full;
  assign bus.ras_empty     = empty;
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_ras_unit;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pc_ras_if #(.ADDR_WIDTH(4), .RAS_DEPTH(4)) bus ();

  pc_ras_unit #(
    .ADDR_WIDTH(4), .RESET_VECTOR(4'd0), .INC_STEP(1), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    string      name;
    logic [3:0] pc;
    logic [2:0] cnt;
    logic [3:0] top;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic ok;
      e = exp_q.pop_front();
      ok = (bus.pc == e.pc) && (bus.ras_count == e.cnt) && (bus.ras_top == e.top) &&
           (bus.err_overflow == e.ovf) && (bus.err_underflow == e.unf) &&
           (bus.ras_full == (e.cnt == 3'd4)) && (bus.ras_empty == (e.cnt == 3'd0));
      n_checks++;
      if (ok) n_pass++;
      else
        $display("FAIL %s: got pc=%0d cnt=%0d top=%0d full=%0b empty=%0b ovf=%0b unf=%0b; want pc=%0d cnt=%0d top=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 e.name, bus.pc, bus.ras_count, bus.ras_top, bus.ras_full, bus.ras_empty,
                 bus.err_overflow, bus.err_underflow, e.pc, e.cnt, e.top,
                 (e.cnt == 3'd4), (e.cnt == 3'd0), e.ovf, e.unf);
    end
  end

  task automatic expect_state(input string nm, input logic [3:0] p, input logic [2:0] c,
                              input logic [3:0] t, input logic o, input logic u);
    exp_t x;
    x.name = nm; x.pc = p; x.cnt = c; x.top = t; x.ovf = o; x.unf = u;
    exp_q.push_back(x);
  endtask

  // Called at posedge+1; applies one op across the next edge, then queues the expected state.
  task automatic step(input string nm, input logic en, input logic [2:0] o,
                      input logic [3:0] tgt, input logic cnd, input logic clr,
                      input logic [3:0] p, input logic [2:0] c, input logic [3:0] t,
                      input logic eo, input logic eu);
    bus.enable  = en;
    bus.op      = o;
    bus.target  = tgt;
    bus.cond    = cnd;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
    expect_state(nm, p, c, t, eo, eu);
    bus.enable  = 1'b0;
    bus.op      = 3'b000;
    bus.clr_err = 1'b0;
    bus.cond    = 1'b0;
  endtask

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010, BR = 3'b011,
                         CALL = 3'b100, RET = 3'b101, RSV = 3'b110;

  initial begin
    reset_n     = 1'b0;
    bus.enable  = 1'b0;
    bus.op      = HOLD;
    bus.target  = 4'd0;
    bus.cond    = 1'b0;
    bus.clr_err = 1'b0;
    #2;
    expect_state("reset", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    step("jump14",      1, JMP,  4'd14, 0, 0, 4'd14, 3'd0, 4'd0, 0, 0);
    step("inc_15",      1, INC,  4'd0,  0, 0, 4'd15, 3'd0, 4'd0, 0, 0);
    step("inc_wrap0",   1, INC,  4'd0,  0, 0, 4'd0,  3'd0, 4'd0, 0, 0);
    step("inc_1",       1, INC,  4'd0,  0, 0, 4'd1,  3'd0, 4'd0, 0, 0);
    step("en0_jump",    0, JMP,  4'd9,  0, 0, 4'd1,  3'd0, 4'd0, 0, 0);
    step("op11x_hold",  1, RSV,  4'd9,  1, 0, 4'd1,  3'd0, 4'd0, 0, 0);
    step("jump2",       1, JMP,  4'd2,  0, 0, 4'd2,  3'd0, 4'd0, 0, 0);
    step("br_not",      1, BR,   4'd8,  0, 0, 4'd3,  3'd0, 4'd0, 0, 0);
    step("br_taken",    1, BR,   4'd8,  1, 0, 4'd8,  3'd0, 4'd0, 0, 0);
    step("jump0_a",     1, JMP,  4'd0,  0, 0, 4'd0,  3'd0, 4'd0, 0, 0);
    step("call5",       1, CALL, 4'd5,  0, 0, 4'd5,  3'd1, 4'd1, 0, 0);
    step("call10",      1, CALL, 4'd10, 0, 0, 4'd10, 3'd2, 4'd6, 0, 0);
    step("en0_call",    0, CALL, 4'd3,  0, 0, 4'd10, 3'd2, 4'd6, 0, 0);
    step("ret_6",       1, RET,  4'd0,  0, 0, 4'd6,  3'd1, 4'd1, 0, 0);
    step("ret_1",       1, RET,  4'd0,  0, 0, 4'd1,  3'd0, 4'd0, 0, 0);
    step("jump0_b",     1, JMP,  4'd0,  0, 0, 4'd0,  3'd0, 4'd0, 0, 0);
    step("fill_call1",  1, CALL, 4'd1,  0, 0, 4'd1,  3'd1, 4'd1, 0, 0);
    step("fill_call2",  1, CALL, 4'd2,  0, 0, 4'd2,  3'd2, 4'd2, 0, 0);
    step("fill_call3",  1, CALL, 4'd3,  0, 0, 4'd3,  3'd3, 4'd3, 0, 0);
    step("fill_call4",  1, CALL, 4'd4,  0, 0, 4'd4,  3'd4, 4'd4, 0, 0);
    step("ovf_call5",   1, CALL, 4'd5,  0, 0, 4'd5,  3'd4, 4'd5, 1, 0);
    step("drain_ret5",  1, RET,  4'd0,  0, 0, 4'd5,  3'd3, 4'd4, 1, 0);
    step("drain_ret4",  1, RET,  4'd0,  0, 0, 4'd4,  3'd2, 4'd3, 1, 0);
    step("drain_ret3",  1, RET,  4'd0,  0, 0, 4'd3,  3'd1, 4'd2, 1, 0);
    step("drain_ret2",  1, RET,  4'd0,  0, 0, 4'd2,  3'd0, 4'd0, 1, 0);
    step("unf_ret",     1, RET,  4'd0,  0, 0, 4'd2,  3'd0, 4'd0, 1, 1);
    step("clr_vs_unf",  1, RET,  4'd0,  0, 1, 4'd2,  3'd0, 4'd0, 0, 1);
    step("clr_hold",    1, HOLD, 4'd0,  0, 1, 4'd2,  3'd0, 4'd0, 0, 0);
    step("unf_again",   1, RET,  4'd0,  0, 0, 4'd2,  3'd0, 4'd0, 0, 1);
    step("clr_en0",     0, RET,  4'd0,  0, 1, 4'd2,  3'd0, 4'd0, 0, 0);
    step("jump15",      1, JMP,  4'd15, 0, 0, 4'd15, 3'd0, 4'd0, 0, 0);
    step("call_wrap",   1, CALL, 4'd3,  0, 0, 4'd3,  3'd1, 4'd0, 0, 0);
    step("ret_wrap",    1, RET,  4'd0,  0, 0, 4'd0,  3'd0, 4'd0, 0, 0);
    step("pre_rst_call",1, CALL, 4'd5,  0, 0, 4'd5,  3'd1, 4'd1, 0, 0);

    // Second CALL is applied, then reset drops between clock edges.
    bus.enable = 1'b1;
    bus.op     = CALL;
    bus.target = 4'd7;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 expect_state("async_reset", 4'd0, 3'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    bus.enable = 1'b0;
    bus.op     = HOLD;
    reset_n    = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_inc",1, INC,  4'd0,  0, 0, 4'd1,  3'd0, 4'd0, 0, 0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      n_checks++;
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
